// File: rtl/data_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_bus_responder: valid/ready bus target with RAM, LED, CYCLES and     |
// | SCRATCH registers, and a fixed number of wait states per transaction.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_bus_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic        resp_valid,
  output logic [31:0] ReadData,
  output logic        err,
  output logic [7:0]  led
);

  localparam int          AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST    = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] ADDR_LED     = 32'h0000_0100;
  localparam logic [31:0] ADDR_CYCLES  = 32'h0000_0104;
  localparam logic [31:0] ADDR_SCRATCH = 32'h0000_0108;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] cycles;
  logic [31:0] scratch;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        hit_led;
  logic        hit_cyc;
  logic        hit_scr;
  logic        hit_mmio;
  logic        hit_ram;
  logic        bad;
  logic [AW-1:0] ram_idx;
  logic [31:0] rd_val;

  // Ready is gated by the raw reset so it is low for the whole reset interval.
  assign req_ready  = (state == IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP);

  // With zero wait states the transaction reaches RESP straight from IDLE,
  // before the latches are loaded, so the live inputs are used there.
  assign cur_write = (state == IDLE) ? MemWrite  : lat_write;
  assign cur_addr  = (state == IDLE) ? DataAddr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? WriteData : lat_wdata;

  assign hit_led  = (cur_addr == ADDR_LED);
  assign hit_cyc  = (cur_addr == ADDR_CYCLES);
  assign hit_scr  = (cur_addr == ADDR_SCRATCH);
  assign hit_mmio = hit_led || hit_cyc || hit_scr;
  assign hit_ram  = !hit_mmio && (cur_addr < RAM_LIMIT);
  assign bad      = (cur_addr[1:0] != 2'b00) || !(hit_mmio || hit_ram) || (cur_write && hit_cyc);
  assign ram_idx  = cur_addr[AW+1:2];

  always_comb begin
    rd_val = 32'h0;
    if (!bad && !cur_write) begin
      if (hit_led)       rd_val = {24'h0, led};
      else if (hit_cyc)  rd_val = cycles;
      else if (hit_scr)  rd_val = scratch;
      else               rd_val = mem[ram_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      cycles    <= 32'h0;
      scratch   <= 32'h0;
      led       <= 8'h00;
      ReadData  <= 32'h0;
      err       <= 1'b0;
    end else begin
      state  <= state_next;
      cycles <= cycles + 32'd1;
      if (accept) begin
        lat_write <= MemWrite;
        lat_addr  <= DataAddr;
        lat_wdata <= WriteData;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
      else               wait_cnt <= 4'd0;
      if (enter_resp) begin
        ReadData <= rd_val;
        err      <= bad;
        if (cur_write && !bad) begin
          if (hit_led) led     <= cur_wdata[7:0];
          if (hit_scr) scratch <= cur_wdata;
        end
      end else begin
        ReadData <= 32'h0;
        err      <= 1'b0;
      end
    end
  end

  // RAM is intentionally not reset; reset forces IDLE, so no write can commit.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !bad && hit_ram) mem[ram_idx] <= cur_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// Directed bench for data_bus_responder: vector table plus multi-cycle sequences,
// with a second instance built for zero wait states.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, MemWrite;
  logic [31:0] DataAddr, WriteData;
  logic        req_ready, resp_valid, err;
  logic [31:0] ReadData;
  logic [7:0]  led;

  logic        v0, w0;
  logic [31:0] a0, d0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;
  logic [7:0]  led0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_responder #(.WAIT_STATES(2), .DEPTH_WORDS(64)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .DataAddr(DataAddr), .WriteData(WriteData),
    .resp_valid(resp_valid), .ReadData(ReadData), .err(err), .led(led)
  );

  data_bus_responder #(.WAIT_STATES(0), .DEPTH_WORDS(64)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .MemWrite(w0), .DataAddr(a0), .WriteData(d0),
    .resp_valid(rv0), .ReadData(rd0), .err(er0), .led(led0)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    MemWrite  = wr;
    DataAddr  = addr;
    WriteData = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not affect the transaction.
    req_valid = 1'b0;
    MemWrite  = ~wr;
    DataAddr  = 32'h0000_0108;
    WriteData = 32'hFFFF_FFFF;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = ReadData;
    er = err;
  endtask

  task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    MemWrite  = 1'b1;
    DataAddr  = addr;
    WriteData = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_led",        32'(led),        32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_rdata",      ReadData,        32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_resp", 32'(resp_valid), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_resp_after_abort", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, c1, c2, v1, v2;
    logic        er;
    int          lat, n;

    vecs[0]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 32'h0,         1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,         32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 32'h100, 32'h0000_01A5, 32'h0,         1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,         32'h0000_00A5, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 32'h012, 32'h0,         32'h0,         1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 32'h400, 32'h0,         32'h0,         1'b1, 8'hA5};
    vecs[6]  = '{1'b1, 32'h104, 32'h0000_1234, 32'h0,         1'b1, 8'hA5};
    vecs[7]  = '{1'b1, 32'h108, 32'hCAFE_F00D, 32'h0,         1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 32'h108, 32'h0,         32'hCAFE_F00D, 1'b0, 8'hA5};
    vecs[9]  = '{1'b1, 32'h0FC, 32'h1234_5678, 32'h0,         1'b0, 8'hA5};
    vecs[10] = '{1'b1, 32'h0FE, 32'hFFFF_FFFF, 32'h0,         1'b1, 8'hA5};
    vecs[11] = '{1'b0, 32'h0FC, 32'h0,         32'h1234_5678, 1'b0, 8'hA5};
    vecs[12] = '{1'b1, 32'h101, 32'h0000_00FF, 32'h0,         1'b1, 8'hA5};
    vecs[13] = '{1'b1, 32'h10C, 32'h0000_0001, 32'h0,         1'b1, 8'hA5};
    vecs[14] = '{1'b0, 32'h10C, 32'h0,         32'h0,         1'b1, 8'hA5};
    vecs[15] = '{1'b0, 32'h108, 32'h0,         32'hCAFE_F00D, 1'b0, 8'hA5};
    vecs[16] = '{1'b1, 32'h100, 32'h0000_003C, 32'h0,         1'b0, 8'h3C};
    vecs[17] = '{1'b0, 32'h100, 32'h0,         32'h0000_003C, 1'b0, 8'h3C};

    reset = 1'b0; req_valid = 1'b0; MemWrite = 1'b0; DataAddr = '0; WriteData = '0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready",  32'(req_ready),  32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata",      ReadData,        32'd0);
    chk("reset_err",        32'(err),        32'd0);
    chk("reset_led",        32'(led),        32'd0);
    chk("reset0_req_ready", 32'(rdy0),       32'd0);
    chk("reset0_resp",      32'(rv0),        32'd0);
    reset = 1'b1;
    #1;
    chk("ready_rises",  32'(req_ready), 32'd1);
    chk("ready0_rises", 32'(rdy0),      32'd1);

    // Zero-wait-state instance: back-to-back CYCLES reads.
    w0 = 1'b0; a0 = 32'h104; v0 = 1'b1;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    chk("w0_resp1",  32'(rv0),  32'd1);
    chk("w0_ready1", 32'(rdy0), 32'd0);
    chk("w0_err1",   32'(er0),  32'd0);
    v1 = rd0;
    @(posedge clk); #1;
    chk("w0_gap_resp",  32'(rv0),  32'd0);
    chk("w0_gap_ready", 32'(rdy0), 32'd1);
    chk("w0_gap_rdata", rd0,       32'd0);
    @(posedge clk); #1;
    chk("w0_resp2", 32'(rv0), 32'd1);
    v2 = rd0;
    v0 = 1'b0;
    chk("w0_cycles_delta", v2 - v1, 32'd2);

    for (int i = 0; i < 18; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i),   rd,         vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i),     32'(er),    32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat),   32'd3);
      chk($sformatf("vec%0d_led", i),     32'(led),   32'(vecs[i].exp_led));
    end

    // Error write to CYCLES must not disturb the counter.
    txn(1'b0, 32'h104, 32'h0, c1, er, lat);
    txn(1'b1, 32'h104, 32'h0000_0000, rd, er, lat);
    chk("cyc_wr_err", 32'(er), 32'd1);
    @(posedge clk); #1;
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_err",        32'(err),        32'd0);
    chk("idle_rdata",      ReadData,        32'd0);
    txn(1'b0, 32'h104, 32'h0, c2, er, lat);
    chk("cycles_delta", c2 - c1, 32'd8);

    // Continuous req_valid: accept every 4 cycles.
    MemWrite = 1'b0; DataAddr = 32'h010; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stream%0d_ready", i), 32'(req_ready),  32'((i % 4) == 0));
      chk($sformatf("stream%0d_resp", i),  32'(resp_valid), 32'((i % 4) == 3));
      if ((i % 4) == 3) chk($sformatf("stream%0d_rdata", i), ReadData, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;

    // Reset during WAIT aborts an SCRATCH write; SCRATCH reads back as reset value.
    abort_write(32'h108, 32'h0000_0055);
    txn(1'b0, 32'h108, 32'h0, rd, er, lat);
    chk("scratch_after_abort", rd, 32'h0);
    chk("led_after_reset",     32'(led), 32'h0);
    txn(1'b0, 32'h010, 32'h0, rd, er, lat);
    chk("ram_survives_reset", rd, 32'hDEAD_BEEF);

    // Aborted RAM write leaves the old contents.
    txn(1'b1, 32'h020, 32'h0000_AAAA, rd, er, lat);
    abort_write(32'h020, 32'h0000_5555);
    txn(1'b0, 32'h020, 32'h0, rd, er, lat);
    chk("ram_abort_no_commit", rd, 32'h0000_AAAA);
    chk("ram_abort_latency",   32'(lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
